avln_st_pkt_arbiter: RTL
========================

AVLN_ST_PKT_ARBITER -- requirements
Module: avln_st_pkt_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of Avalon-ST source ports (2..8).
REQ-002 SHALL use package global_types parameters W (32) and BpW (4); EW = $clog2(BpW) (2).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_data, input, N_SRC*W, per-source data; source i occupies bits [i*W +: W].
REQ-006 SHALL have ports in_sop, in_eop, in_valid, input, N_SRC each, per-source flags.
REQ-007 SHALL have port in_empty, input, N_SRC*EW, per-source empty byte count.
REQ-008 SHALL have port in_ready, output, N_SRC, per-source backpressure.
REQ-009 SHALL have ports out_data (W), out_sop, out_eop, out_empty (EW), out_valid, all outputs, merged stream.
REQ-010 SHALL have port out_ready, input, 1, sink backpressure.
REQ-011 SHALL have port grant, output, N_SRC, one-hot owner of the output; all-zero when idle.
REQ-012 SHALL have port proto_err, output, 1, sticky protocol-error flag.

Function
REQ-013 SHALL implement FSM states IDLE and PASS.
REQ-014 In IDLE, source i SHALL be eligible iff in_valid[i] && in_sop[i].
REQ-015 In IDLE with at least one eligible source, SHALL pick the first eligible index scanning round-robin from last+1 mod N_SRC, register it into grant, and enter PASS next cycle.
REQ-016 In IDLE, all in_ready SHALL be 0 and out_valid SHALL be 0; arbitration latency is exactly one cycle.
REQ-017 In PASS with granted source g, out_data/sop/eop/empty/valid SHALL equal source g's inputs combinationally; in_ready[g] = out_ready; in_ready of every other source = 0.
REQ-018 A beat transfers when out_valid && out_ready; non-transfer cycles SHALL change no state.
REQ-019 On a transfer with out_eop=1 in PASS, SHALL set last = g, clear grant, return to IDLE; new arbitration happens in that IDLE cycle (one bubble cycle between packets minimum).
REQ-020 A single-beat packet (sop=eop=1) SHALL complete PASS in one transfer.
REQ-021 In PASS, a transfer with out_sop=1 after the first beat of the packet SHALL set proto_err and the beat SHALL still pass through.
REQ-022 A non-granted source holding valid without sop in IDLE SHALL be ineligible and SHALL NOT set proto_err.
REQ-023 proto_err SHALL remain 1 until reset.
REQ-024 grant SHALL never hold more than one bit set.

Reset
REQ-025 On reset, state = IDLE, grant = 0, last = N_SRC-1 (source 0 highest priority first), proto_err = 0.
REQ-026 During and on the cycle after reset, out_valid = 0 and in_ready = 0.
REQ-027 Reset mid-packet SHALL abandon the packet with no further beats forwarded; no completion is emitted.

Configuration
REQ-028 Macro AVLN_ARB_PKT_STATS_EN SHALL control per-source packet counters.
REQ-029 With AVLN_ARB_PKT_STATS_EN defined: output pkt_count, N_SRC*16; counter i increments on each eop transfer by source i, wraps 16'hFFFF -> 0, clears on reset.
REQ-030 Without AVLN_ARB_PKT_STATS_EN: port pkt_count SHALL be absent and no counter logic synthesized; all other behaviour identical.

Verification
REQ-031 Reset, then sources 0 and 2 present 3-beat packets simultaneously, out_ready=1 -> grant=0001 for 3 beats, 1 idle cycle, grant=0100 for 3 beats; output data ordered source 0 then 2.
REQ-032 All 4 sources continuously present 1-beat packets -> grant sequence 0001,0010,0100,1000,0001 with one bubble between each.
REQ-033 Source 1 in a 4-beat packet, out_ready deasserted for 5 cycles on beat 2 -> out_data holds beat 2, in_ready[1]=0, other in_ready=0, no beat lost or duplicated.
REQ-034 Source 3 sends sop on beat 1 and again on beat 3 -> both beats forwarded, proto_err=1 from cycle after beat 3 until reset.
REQ-035 Reset asserted on beat 2 of a 5-beat packet from source 1 -> next cycle grant=0, out_valid=0, proto_err=0; afterwards source 0 wins over simultaneous source 1.
REQ-036 With AVLN_ARB_PKT_STATS_EN, 65537 single-beat packets from source 0 -> pkt_count[15:0]=1; other counters 0.

Source files
------------

// File: rtl/global_types.sv
// Shared bus-geometry constants.
//   W   : data word width in bits
//   BpW : bytes per word
package global_types;
  parameter int unsigned W   = 32;
  parameter int unsigned BpW = 4;
endpackage

// File: rtl/avln_st_pkt_arbiter.sv
// avln_st_pkt_arbiter
// Packet-granular round-robin arbiter merging N_SRC Avalon-ST sources into one
// stream. A source wins only while presenting a start-of-packet beat and keeps
// the output until its end-of-packet beat transfers.
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_data/sop/eop/
//   in_empty/in_valid   : per-source stream, source i at slice i
//   in_ready            : per-source backpressure (only the owner sees out_ready)
//   out_data/sop/eop/
//   out_empty/out_valid : merged stream, combinational from the owner
//   out_ready           : sink backpressure
//   grant               : one-hot registered owner, zero while idle
//   proto_err           : sticky; set by a mid-packet sop beat
//   pkt_count           : per-source 16-bit completed-packet counters, present
//                         only when AVLN_ARB_PKT_STATS_EN is defined
module avln_st_pkt_arbiter
  import global_types::*;
#(
  parameter int unsigned N_SRC = 4,
  localparam int unsigned EW = $clog2(BpW)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC*W-1:0]   in_data,
  input  logic [N_SRC-1:0]     in_sop,
  input  logic [N_SRC-1:0]     in_eop,
  input  logic [N_SRC*EW-1:0]  in_empty,
  input  logic [N_SRC-1:0]     in_valid,
  output logic [N_SRC-1:0]     in_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [EW-1:0]        out_empty,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_SRC-1:0]     grant,
  output logic                 proto_err
`ifdef AVLN_ARB_PKT_STATS_EN
  ,
  output logic [N_SRC*16-1:0]  pkt_count
`endif
);

  localparam int unsigned SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [N_SRC-1:0] GRANT_LSB = {{(N_SRC-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, PASS} state_t;

  state_t        state;
  logic [SW-1:0] gidx;
  logic [SW-1:0] last;
  logic          first_beat;

  logic [SW-1:0] pick_idx;
  logic          pick_vld;
  logic [SW-1:0] cand;
  logic          xfer;

  logic [W-1:0]  src_data  [N_SRC];
  logic [EW-1:0] src_empty [N_SRC];

  // Unpack the flat per-source buses for indexed selection.
  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_data[i]  = in_data[i*W +: W];
    assign src_empty[i] = in_empty[i*EW +: EW];
  end

  // Round-robin pick: scan from the farthest candidate back to last+1 so the
  // final hit is the first eligible source after last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = SW'((int'(last) + k) % N_SRC);
      if (in_valid[cand] && in_sop[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Output mux and backpressure routing; nothing passes while idle or in reset.
  always_comb begin
    out_data  = src_data[gidx];
    out_empty = src_empty[gidx];
    out_sop   = in_sop[gidx];
    out_eop   = in_eop[gidx];
    out_valid = (state == PASS) && !reset && in_valid[gidx];
    in_ready  = '0;
    if ((state == PASS) && !reset) begin
      in_ready[gidx] = out_ready;
    end
  end

  assign xfer = out_valid && out_ready;

  // Arbitration FSM with registered grant and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      last       <= SW'(N_SRC - 1);
      first_beat <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state      <= PASS;
            grant      <= GRANT_LSB << pick_idx;
            gidx       <= pick_idx;
            first_beat <= 1'b1;
          end
        end
        PASS: begin
          if (xfer) begin
            first_beat <= 1'b0;
            // A second sop inside a packet is flagged but still forwarded.
            if (out_sop && !first_beat) begin
              proto_err <= 1'b1;
            end
            if (out_eop) begin
              state <= IDLE;
              grant <= '0;
              last  <= gidx;
            end
          end
        end
      endcase
    end
  end

`ifdef AVLN_ARB_PKT_STATS_EN
  logic [15:0] cnt [N_SRC];

  // Count completed packets per source; counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SRC; i++) begin
        cnt[i] <= '0;
      end
    end else if ((state == PASS) && xfer && out_eop) begin
      cnt[gidx] <= cnt[gidx] + 16'd1;
    end
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_cnt_out
    assign pkt_count[i*16 +: 16] = cnt[i];
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule
